// File: rtl/key_sequence_player_pkg.sv
// Shared lock definitions: key codes, player state encoding and a
// millisecond-to-cycle helper used to size timers.
package lock_pkg;

  localparam logic [3:0] KEY_0 = 4'b0001;
  localparam logic [3:0] KEY_1 = 4'b0010;
  localparam logic [3:0] KEY_2 = 4'b0100;
  localparam logic [3:0] KEY_3 = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP,
    ST_FINISH
  } player_state_t;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                               input int unsigned ms);
    return (clk_freq / 1000) * ms;
  endfunction

endpackage

// File: rtl/key_sequence_player_if.sv
// Control/pulse bundle between a sequence source and the key player.
//   master: drives start, key_seq (and abort when
//           KEY_SEQUENCE_PLAYER_ABORT_EN is defined)
//   slave : the player; drives busy, done, btn_pulse, is_a_key_pressed,
//           key_index
// key_seq carries the key code (one nibble per key, MS nibble first);
// "sequence" itself is a reserved word.
interface key_sequence_player_if #(
  parameter int num_keys = 4
);
  localparam int IDX_W = $clog2(num_keys + 1);

  logic                    start;
  logic [4*num_keys-1:0]   key_seq;
  logic                    busy;
  logic                    done;
  logic [3:0]              btn_pulse;
  logic                    is_a_key_pressed;
  logic [IDX_W-1:0]        key_index;
`ifdef KEY_SEQUENCE_PLAYER_ABORT_EN
  logic                    abort;

  modport master (output start, key_seq, abort,
                  input  busy, done, btn_pulse, is_a_key_pressed, key_index);
  modport slave  (input  start, key_seq, abort,
                  output busy, done, btn_pulse, is_a_key_pressed, key_index);
`else
  modport master (output start, key_seq,
                  input  busy, done, btn_pulse, is_a_key_pressed, key_index);
  modport slave  (input  start, key_seq,
                  output busy, done, btn_pulse, is_a_key_pressed, key_index);
`endif

endinterface

// File: rtl/key_sequence_player_gap_timer.sv
// gap_timer: loadable down-counter with terminal-count flag.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (wins over en)
//   en        : decrement while nonzero
//   tc        : count == 1, i.e. the last cycle of the loaded interval
module gap_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (en && cnt != '0)  cnt <= cnt - W'(1);
  end

  assign tc = (cnt == W'(1));

endmodule

// File: rtl/key_sequence_player.sv
// key_sequence_player: replays a captured key code as one-hot style
// single-cycle btn_pulse strobes with a programmable inter-key gap.
//   clk, rst : clock, synchronous active-high reset
//   bus      : key_sequence_player_if.slave (start/key_seq in,
//              busy/done/btn_pulse/is_a_key_pressed/key_index out)
// Optional: KEY_SEQUENCE_PLAYER_ABORT_EN adds bus.abort, which ends
// playback early through FINISH (done still strobes once).
// Outputs are registered and computed on entry to a state, so a pulse
// is visible in the same cycle the FSM sits in PRESS.
module key_sequence_player
  import lock_pkg::*;
#(
  parameter int unsigned clk_freq = 125_000_000,
  parameter int unsigned gap_ms   = 10,
  parameter int          num_keys = 4
) (
  input logic                  clk,
  input logic                  rst,
  key_sequence_player_if.slave bus
);

  localparam int unsigned GAP_CYCLES = ms_to_cycles(clk_freq, gap_ms);
  localparam int          CNT_W      = $clog2(GAP_CYCLES + 1);
  localparam int          IDX_W      = $clog2(num_keys + 1);
  localparam int          SEQ_W      = 4 * num_keys;
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(num_keys);

  player_state_t    state;
  logic [SEQ_W-1:0] shreg;
  logic [IDX_W-1:0] key_idx;
  logic             busy_r, done_r, press_r;
  logic [3:0]       pulse_r;
  logic             gap_tc;
  logic             abort_req;
  logic [3:0]       next_nib;
  logic             nib_ok;

`ifdef KEY_SEQUENCE_PLAYER_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // Nibble that the next PRESS will present: straight from the input on
  // capture, otherwise from the already-shifted register.
  assign next_nib = (state == ST_IDLE) ? bus.key_seq[SEQ_W-1 -: 4]
                                       : shreg[SEQ_W-1 -: 4];
  assign nib_ok   = (next_nib != 4'b0000) &&
                    ((state == ST_IDLE) || (key_idx < MAX_IDX));

  gap_timer #(.W(CNT_W)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_PRESS && press_r),
    .load_val (CNT_W'(GAP_CYCLES)),
    .en       (state == ST_GAP),
    .tc       (gap_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      key_idx <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      press_r <= 1'b0;
      pulse_r <= '0;
    end else begin
      done_r  <= 1'b0;
      press_r <= 1'b0;
      pulse_r <= '0;
      unique case (state)
        ST_IDLE: if (bus.start) begin
          shreg   <= bus.key_seq;
          key_idx <= '0;
          busy_r  <= 1'b1;
          state   <= ST_PRESS;
          if (nib_ok) begin
            pulse_r <= next_nib;
            press_r <= 1'b1;
          end
        end
        ST_PRESS: begin
          if (press_r) begin
            key_idx <= key_idx + IDX_W'(1);
            shreg   <= shreg << 4;
          end
          // No pulse this PRESS means zero nibble or key limit reached.
          if (abort_req || !press_r) begin
            state  <= ST_FINISH;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            state  <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (abort_req) begin
            state  <= ST_FINISH;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else if (gap_tc) begin
            state <= ST_PRESS;
            if (nib_ok) begin
              pulse_r <= next_nib;
              press_r <= 1'b1;
            end
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy             = busy_r;
  assign bus.done             = done_r;
  assign bus.btn_pulse        = pulse_r;
  assign bus.is_a_key_pressed = press_r;
  assign bus.key_index        = key_idx;

endmodule

// File: tb/tb_key_sequence_player.sv
// Self-checking bench for key_sequence_player (clk_freq=1000, gap_ms=3,
// num_keys=4 -> 3-cycle gap). Expected outputs come from a per-cycle
// model derived from the key list: pulse k at cycle 1+k*(G+1), done
// one cycle after the final empty PRESS.
module tb_key_sequence_player;

  localparam int G = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  key_sequence_player_if #(.num_keys(4)) bus ();

  key_sequence_player #(.clk_freq(1000), .gap_ms(3), .num_keys(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Number of keys played: nibbles up to the first zero, max 4.
  function automatic int num_of(input logic [15:0] s);
    int  n = 0;
    bit  stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!stop && s[15-4*i -: 4] != 4'b0000) n++;
      else stop = 1'b1;
    end
    return n;
  endfunction

  function automatic int fin_of(input logic [15:0] s);
    return 2 + num_of(s) * (G + 1);
  endfunction

  // {busy, done, btn_pulse, is_a_key_pressed, key_index} at cycle c
  // after a start sampled at the end of cycle 0.
  function automatic logic [9:0] model(input logic [15:0] s, input int c);
    int         n    = num_of(s);
    int         fin  = fin_of(s);
    int         kidx = 0;
    logic [3:0] btn  = 4'b0000;
    for (int i = 0; i < n; i++) begin
      if (c == 1 + i * (G + 1)) btn = s[15-4*i -: 4];
      if (1 + i * (G + 1) < c)  kidx++;
    end
    return {(c >= 1 && c < fin), (c == fin), btn, |btn, 3'(kidx)};
  endfunction

  function automatic logic [9:0] obs();
    return {bus.busy, bus.done, bus.btn_pulse, bus.is_a_key_pressed, bus.key_index};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.key_seq = 16'h4121;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++;
    if (obs() !== 10'b0) begin
      errors++;
      $display("FAIL reset: got %b want %b", obs(), 10'b0);
    end
    bus.start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_playback(input logic [15:0] s, input string name);
    int fin = fin_of(s);
    for (int c = 0; c <= fin + 1; c++) begin
      if (c > 0) begin
        @(negedge clk);
        checks++;
        if (obs() !== model(s, c)) begin
          errors++;
          $display("FAIL %s seq=%h cycle %0d: got %b want %b", name, s, c, obs(), model(s, c));
        end
      end
      bus.start   = (c == 0);
      bus.key_seq = (c == 0) ? s : 16'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_restart_ignored();
    logic [15:0] s = 16'h4121;
    int fin = fin_of(s);
    for (int c = 0; c <= fin + 1; c++) begin
      if (c > 0) begin
        @(negedge clk);
        checks++;
        if (obs() !== model(s, c)) begin
          errors++;
          $display("FAIL restart_ignored cycle %0d: got %b want %b", c, obs(), model(s, c));
        end
      end
      bus.start   = (c == 0 || c == 6);
      bus.key_seq = (c == 0) ? s : 16'h8888;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] s = 16'h4121;
    logic [9:0]  exp;
    int fin = fin_of(s);
    for (int c = 0; c <= 10 + fin + 1; c++) begin
      if (c > 0) begin
        @(negedge clk);
        exp = (c <= 7) ? model(s, c) : (c < 10) ? 10'b0 : model(s, c - 10);
        checks++;
        if (obs() !== exp) begin
          errors++;
          $display("FAIL reset_mid cycle %0d: got %b want %b", c, obs(), exp);
        end
      end
      rst         = (c == 7);
      bus.start   = (c == 0 || c == 10);
      bus.key_seq = s;
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] s = 16'h2840;
    logic [9:0]  exp;
    int fin = fin_of(s);
    for (int c = 0; c <= 2 * (fin + 1); c++) begin
      if (c > 0) begin
        @(negedge clk);
        exp = (c <= fin + 1) ? model(s, c) : model(s, c - (fin + 1));
        checks++;
        if (obs() !== exp) begin
          errors++;
          $display("FAIL back_to_back cycle %0d: got %b want %b", c, obs(), exp);
        end
      end
      bus.start   = (c < 2 * (fin + 1));
      bus.key_seq = s;
      @(posedge clk); #1;
    end
  endtask

`ifdef KEY_SEQUENCE_PLAYER_ABORT_EN
  task automatic test_abort();
    logic [15:0] s = 16'h4121;
    logic [9:0]  exp;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) begin
        @(negedge clk);
        exp = (c <= 6) ? model(s, c) : (c == 7) ? 10'b01_0000_0_010 : 10'b00_0000_0_010;
        checks++;
        if (obs() !== exp) begin
          errors++;
          $display("FAIL abort cycle %0d: got %b want %b", c, obs(), exp);
        end
      end
      bus.abort   = (c == 6);
      bus.start   = (c == 0);
      bus.key_seq = s;
      @(posedge clk); #1;
    end
    bus.abort = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [15:0] s;
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 4; i++)
        s[15-4*i -: 4] = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      test_playback(s, "random");
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.key_seq = '0;
`ifdef KEY_SEQUENCE_PLAYER_ABORT_EN
    bus.abort   = 1'b0;
`endif
    test_reset();
    test_playback(16'h4121, "full4");
    test_playback(16'h2804, "zero_term");
    test_playback(16'h0000, "all_zero");
    test_playback(16'hF000, "non_onehot");
    test_restart_ignored();
    test_reset_mid();
    test_back_to_back();
`ifdef KEY_SEQUENCE_PLAYER_ABORT_EN
    test_abort();
`endif
    test_random();
    test_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
